data_mem_responder: RTL

Responder side of the pipeline's data-memory port. It accepts MemRead/MemWrite requests from the MEM stage and serves them from an internal word array after a configurable access latency. It holds the pipeline with stall_o until each access completes. It replaces the zero-latency data memory so the hazard/stall path can be exercised against realistic memory timing.

---
 rtl/data_mem_responder.sv | 195 +++++++++++++++++++
 1 files changed

// File: rtl/data_mem_responder.sv
// Data-memory responder: serves MEM-stage loads/stores from a word array after LATENCY cycles, stalling the pipeline meanwhile.
// Optional build macro DMEM_ALIGN_CHECK_EN: reject byte-misaligned accesses with a one-cycle error completion.
module data_mem_responder #(
    parameter int unsigned DEPTH_WORDS = 256,
    parameter int unsigned LATENCY     = 3
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic [31:0] addr_i,
    input  logic [31:0] write_data_i,
    input  logic        MemRead_i,
    input  logic        MemWrite_i,
    output logic [31:0] data_o,
    output logic        stall_o,
    output logic        ack_o,
    output logic        err_o
);

    localparam int unsigned AW = $clog2(DEPTH_WORDS);
    localparam int unsigned CW = $clog2(LATENCY) + 1;
    localparam logic [CW-1:0] CNT_LOAD = CW'(LATENCY - 1);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);
    localparam logic [CW-1:0] CNT_ZERO = CW'(0);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    function automatic logic [AW-1:0] word_index(input logic [31:0] addr);
        return addr[AW+1:2];
    endfunction

    state_t         state_r;
    state_t         state_nxt_s;
    logic [CW-1:0]  cnt_r;
    logic [AW-1:0]  idx_r;
    logic [31:0]    wdata_r;
    logic           rd_r;
    logic           wr_r;
    logic           bad_r;
    logic [31:0]    data_r;
    logic           ack_r;
    logic           err_r;
    logic [31:0]    mem_r [DEPTH_WORDS];

    logic           req_s;
    logic           misalign_s;
    logic           illegal_s;
    logic           accept_s;
    logic           stall_s;
    logic [AW-1:0]  op_idx_s;
    logic [31:0]    op_wdata_s;
    logic           op_rd_s;
    logic           op_wr_s;
    logic           op_bad_s;
    logic           enter_done_s;
    logic           commit_rd_s;
    logic           commit_wr_s;
    logic           addr_unused_s;

    assign addr_unused_s = ^{addr_i[31:AW+2], addr_i[1:0]};

    assign req_s    = MemRead_i | MemWrite_i;
    assign accept_s = (state_r == IDLE) && req_s;

`ifdef DMEM_ALIGN_CHECK_EN
    assign misalign_s = |addr_i[1:0];
`else
    assign misalign_s = 1'b0;
`endif

    assign illegal_s = (MemRead_i & MemWrite_i) | misalign_s;

    // Operation source: live inputs in the accept cycle (needed when DONE follows IDLE directly), captured copy otherwise.
    always_comb begin
        op_idx_s   = idx_r;
        op_wdata_s = wdata_r;
        op_rd_s    = rd_r;
        op_wr_s    = wr_r;
        op_bad_s   = bad_r;
        if (accept_s) begin
            op_idx_s   = word_index(addr_i);
            op_wdata_s = write_data_i;
            op_rd_s    = MemRead_i;
            op_wr_s    = MemWrite_i;
            op_bad_s   = illegal_s;
        end else begin
            op_idx_s   = idx_r;
            op_wdata_s = wdata_r;
            op_rd_s    = rd_r;
            op_wr_s    = wr_r;
            op_bad_s   = bad_r;
        end
    end

    // Next-state and stall decode.
    always_comb begin
        state_nxt_s = state_r;
        stall_s     = 1'b0;
        case (state_r)
            IDLE: begin
                if (req_s) begin
                    stall_s = 1'b1;
                    if (misalign_s || (LATENCY == 1)) begin
                        state_nxt_s = DONE;
                    end else begin
                        state_nxt_s = BUSY;
                    end
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            BUSY: begin
                stall_s = 1'b1;
                if (cnt_r == CNT_ONE) begin
                    state_nxt_s = DONE;
                end else begin
                    state_nxt_s = BUSY;
                end
            end
            DONE: begin
                state_nxt_s = IDLE;
            end
            default: begin
                state_nxt_s = IDLE;
            end
        endcase
    end

    // Reset must drop the stall at once, even with a request still on the inputs.
    assign stall_o = stall_s & ~rst_i;

    assign enter_done_s = (state_nxt_s == DONE) && (state_r != DONE) && !rst_i;
    assign commit_rd_s  = enter_done_s & op_rd_s & ~op_bad_s;
    assign commit_wr_s  = enter_done_s & op_wr_s & ~op_bad_s;

    // State register.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Latency counter and request capture.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            cnt_r   <= CNT_ZERO;
            idx_r   <= {AW{1'b0}};
            wdata_r <= 32'h0000_0000;
            rd_r    <= 1'b0;
            wr_r    <= 1'b0;
            bad_r   <= 1'b0;
        end else if (accept_s) begin
            cnt_r   <= CNT_LOAD;
            idx_r   <= word_index(addr_i);
            wdata_r <= write_data_i;
            rd_r    <= MemRead_i;
            wr_r    <= MemWrite_i;
            bad_r   <= illegal_s;
        end else if (state_r == BUSY) begin
            cnt_r <= cnt_r - CNT_ONE;
        end
    end

    // Completion pulses and load data, all asserted on the edge entering DONE.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            data_r <= 32'h0000_0000;
            ack_r  <= 1'b0;
            err_r  <= 1'b0;
        end else begin
            ack_r <= enter_done_s;
            err_r <= enter_done_s & op_bad_s;
            if (commit_rd_s) begin
                data_r <= mem_r[op_idx_s];
            end
        end
    end

    // Word array; deliberately not cleared by reset.
    always_ff @(posedge clk_i) begin
        if (commit_wr_s) begin
            mem_r[op_idx_s] <= op_wdata_s;
        end
    end

    assign data_o = data_r;
    assign ack_o  = ack_r;
    assign err_o  = err_r;

endmodule
